// File: rtl/alu.sv
// alu: registered arithmetic/logic unit with one cycle of latency.
//
// Two unsigned WIDTH-bit operands are combined according to a 3-bit select.
// The WIDTH+1-bit result is captured on the rising clock edge. Its MSB carries
// the carry (ADD), the borrow (SUB) or the shifted-out bit (SHL/SHR). For the
// logic ops the MSB is always 0.
//
// Optional feature: defining ALU_ZERO_FLAG_EN adds a registered zero flag.
// The flag is 1 when the captured out[WIDTH-1:0] is zero; out[WIDTH] is ignored.
// The flag resets to 1.
//
// Parameters:
//   WIDTH  operand width in bits (2..64), default 8
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset, clears the registered outputs
//   a     in   [WIDTH-1:0] operand A, unsigned
//   b     in   [WIDTH-1:0] operand B, unsigned
//   sel   in   [2:0] op select:
//              000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 SHR
//   out   out  [WIDTH:0] registered result; out[WIDTH] = carry/borrow/shift-out
//   zero  out  registered zero flag (present only with ALU_ZERO_FLAG_EN)
module alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
`ifdef ALU_ZERO_FLAG_EN
  output logic [WIDTH:0]   out,
  output logic             zero
`else
  output logic [WIDTH:0]   out
`endif
);

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpNot = 3'b101,
    OpShl = 3'b110,
    OpShr = 3'b111
  } op_e;

  logic [WIDTH:0] w_result;
  logic [WIDTH:0] r_out;

  always_comb begin
    w_result = '0;
    unique case (op_e'(sel))
      OpAdd:   w_result = {1'b0, a} + {1'b0, b};
      // The WIDTH+1-bit wrap leaves the MSB set exactly when a < b.
      OpSub:   w_result = {1'b0, a} - {1'b0, b};
      OpAnd:   w_result = {1'b0, a & b};
      OpOr:    w_result = {1'b0, a | b};
      OpXor:   w_result = {1'b0, a ^ b};
      OpNot:   w_result = {1'b0, ~a};
      OpShl:   w_result = {a, 1'b0};
      // The shifted-out LSB goes into the MSB position.
      OpShr:   w_result = {a[0], 1'b0, a[WIDTH-1:1]};
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      r_out <= w_result;
    end
  end

  assign out = r_out;

`ifdef ALU_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero <= 1'b1;
    end else begin
      r_zero <= (w_result[WIDTH-1:0] == '0);
    end
  end

  assign zero = r_zero;
`endif

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu (WIDTH=8).
// Expected results come from an arithmetic reference model of the op table.
module tb_alu;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   sel;
  logic [W:0]   out;
`ifdef ALU_ZERO_FLAG_EN
  logic         zero;
`endif

  int n_checks = 0;
  int n_errors = 0;

  alu #(.WIDTH(W)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .sel  (sel),
`ifdef ALU_ZERO_FLAG_EN
    .out  (out),
    .zero (zero)
`else
    .out  (out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint unsigned obs,
                          input longint unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the op table, result mod 2^(W+1).
  function automatic longint unsigned model(input longint unsigned ma, input longint unsigned mb,
                                            input int unsigned msel);
    longint unsigned full;
    longint unsigned mask;
    full = 64'd1 << W;
    mask = full - 1;
    case (msel)
      0: return ma + mb;
      1: return (ma + 2 * full - mb) % (2 * full);
      2: return ma & mb;
      3: return ma | mb;
      4: return ma ^ mb;
      5: return mask - ma;
      6: return ma * 2;
      default: return (ma % 2) * full + ma / 2;
    endcase
  endfunction

  task automatic check_zero(input string tag, input longint unsigned exp_out);
`ifdef ALU_ZERO_FLAG_EN
    check_eq(tag, zero, ((exp_out % (64'd1 << W)) == 0) ? 1 : 0);
`endif
  endtask

  // Drive one op at the falling edge, check out just after the next rising edge.
  task automatic run_op(input string tag, input int unsigned ia, input int unsigned ib,
                        input int unsigned isel);
    longint unsigned exp;
    @(negedge clk);
    a   = W'(ia);
    b   = W'(ib);
    sel = 3'(isel);
    exp = model(ia, ib, isel);
    @(posedge clk);
    #1;
    check_eq(tag, out, exp);
    check_zero({tag, "_zero"}, exp);
  endtask

  initial begin
    longint unsigned hold;
    int unsigned     ra;
    int unsigned     rb;
    rst = 1'b1;
    a   = '0;
    b   = '0;
    sel = '0;
    #12;
    check_eq("reset_out", out, 0);
`ifdef ALU_ZERO_FLAG_EN
    check_eq("reset_zero", zero, 1);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors.
    run_op("add_300", 200, 100, 0);
    check_eq("add_300_abs", out, 9'h12C);
    run_op("add_ones", 255, 255, 0);
    check_eq("add_ones_abs", out, 9'h1FE);
    run_op("sub_pos", 200, 100, 1);
    check_eq("sub_pos_abs", out, 9'd100);
    run_op("sub_borrow", 100, 200, 1);
    check_eq("sub_borrow_abs", out, 9'h19C);
    run_op("sub_eq", 77, 77, 1);
    check_eq("sub_eq_abs", out, 0);
    run_op("and", 'hF0, 'h3C, 2);
    check_eq("and_abs", out, 9'h030);
    run_op("or", 'hF0, 'h3C, 3);
    check_eq("or_abs", out, 9'h0FC);
    run_op("xor", 'hF0, 'h3C, 4);
    check_eq("xor_abs", out, 9'h0CC);
    run_op("not", 'h0F, 'hAA, 5);
    check_eq("not_abs", out, 9'h0F0);
    run_op("shl", 'h81, 0, 6);
    check_eq("shl_abs", out, 9'h102);
    run_op("shr", 'h81, 0, 7);
    check_eq("shr_abs", out, 9'h140);

    // Inputs changing between edges must not reach out.
    hold = model('h81, 0, 7);
    #2;
    a   = 8'h55;
    b   = 8'h0F;
    sel = 3'b000;
    #3;
    check_eq("mid_cycle_hold", out, hold);

    // Asynchronous reset mid-cycle with a pending op.
    run_op("pre_reset", 200, 100, 0);
    @(negedge clk);
    a   = 8'd10;
    b   = 8'd20;
    sel = 3'b000;
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_out", out, 0);
`ifdef ALU_ZERO_FLAG_EN
    check_eq("async_rst_zero", zero, 1);
`endif
    @(posedge clk);
    #1;
    check_eq("rst_held_out", out, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_release_out", out, 0);
    @(posedge clk);
    #1;
    check_eq("first_capture", out, model(10, 20, 0));

    // Random sweep: 5 seeded pairs x all 8 ops, back-to-back.
    void'($urandom(32'd2024));
    for (int p = 0; p < 5; p++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      for (int s = 0; s < 8; s++) begin
        run_op($sformatf("sweep_p%0d_s%0d", p, s), ra, rb, s);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Guard against a hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
